div_sequencer: RTL and testbench

- Control FSM that drives one row of divider bitslices through a signed WIDTH-bit division.
- Operands are loaded as magnitudes through the operand negators. The block then runs WIDTH restoring trial-subtract/shift iterations.
- Finally it sign-corrects and stores the quotient and remainder.
- It is the initiator end of the bitslice control interface: it generates every LOAD/STORE/INV/Cin line the slices consume and samples the MSB-slice carry and sign flags.

---
 rtl/div_sequencer_if.sv | 43 ++++
 rtl/div_sequencer.sv | 112 +++++++++++
 tb/tb_div_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - divider sequencer to bitslice row control interface
// Master is the sequencer; slave is the bitslice row together with the host start/done side.
interface div_sequencer_if;
  logic start;
  logic op1_sign;
  logic op2_sign;
  logic op1_zero;
  logic trial_cout;
  logic load_acc;
  logic store_acc;
  logic load_divh;
  logic load_divl;
  logic inv_op1;
  logic op1_inv_cin;
  logic inv_op2;
  logic op2_inv_cin;
  logic acc_inv_cin;
  logic inv_result;
  logic result_inv_cin;
  logic inv_rem;
  logic result_np_0;
  logic store_quot;
  logic store_rem;
  logic busy;
  logic done;
  logic div_zero;

  modport master (
    input  start, op1_sign, op2_sign, op1_zero, trial_cout,
    output load_acc, store_acc, load_divh, load_divl,
    output inv_op1, op1_inv_cin, inv_op2, op2_inv_cin, acc_inv_cin,
    output inv_result, result_inv_cin, inv_rem, result_np_0,
    output store_quot, store_rem, busy, done, div_zero
  );

  modport slave (
    output start, op1_sign, op2_sign, op1_zero, trial_cout,
    input  load_acc, store_acc, load_divh, load_divl,
    input  inv_op1, op1_inv_cin, inv_op2, op2_inv_cin, acc_inv_cin,
    input  inv_result, result_inv_cin, inv_rem, result_np_0,
    input  store_quot, store_rem, busy, done, div_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - control FSM for a signed restoring bitslice divider row
// Loads operand magnitudes, runs WIDTH trial-subtract/shift steps, then sign-corrects and stores.
module div_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, STORE, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          s1;
  logic          s2;
  logic          z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            s1 <= bus.op1_sign;
            s2 <= bus.op2_sign;
            z  <= bus.op1_zero;
          end
        end
        LOAD: cnt <= '0;
        // Saturate at the last iteration so the counter never reaches WIDTH.
        ITER: if (cnt != LAST) cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.load_acc       = 1'b0;
    bus.store_acc      = 1'b0;
    bus.load_divh      = 1'b0;
    bus.load_divl      = 1'b0;
    bus.inv_op1        = 1'b0;
    bus.op1_inv_cin    = 1'b0;
    bus.inv_op2        = 1'b0;
    bus.op2_inv_cin    = 1'b0;
    bus.acc_inv_cin    = 1'b0;
    bus.inv_result     = 1'b0;
    bus.result_inv_cin = 1'b0;
    bus.inv_rem        = 1'b0;
    bus.result_np_0    = 1'b1;
    bus.store_quot     = 1'b0;
    bus.store_rem      = 1'b0;
    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    bus.div_zero       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.busy        = 1'b1;
        bus.load_acc    = 1'b1;
        bus.store_acc   = 1'b1;
        bus.load_divh   = 1'b1;
        bus.load_divl   = 1'b1;
        bus.inv_op1     = s1;
        bus.op1_inv_cin = s1;
        bus.inv_op2     = s2;
        bus.op2_inv_cin = s2;
        state_nxt       = z ? STORE : ITER;
      end
      ITER: begin
        // No borrow keeps the difference; a borrow restores by shifting only.
        bus.busy        = 1'b1;
        bus.acc_inv_cin = 1'b1;
        bus.load_divh   = bus.trial_cout;
        bus.result_np_0 = ~bus.trial_cout;
        if (cnt == LAST) state_nxt = STORE;
      end
      STORE: begin
        bus.busy = 1'b1;
        if (!z) begin
          bus.store_quot     = 1'b1;
          bus.store_rem      = 1'b1;
          bus.inv_result     = s1 ^ s2;
          bus.result_inv_cin = s1 ^ s2;
          bus.inv_rem        = s2;
        end
        state_nxt = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.div_zero = z;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard testbench for div_sequencer
// Transactions are queued when Start is driven and retired on Done.
module tb_div_sequencer;
  localparam int WIDTH = 8;
  localparam int CW    = 4;
  // IDLE edge + LOAD + WIDTH ITER + STORE + DONE
  localparam int PERIOD_DIV = WIDTH + 4;

  typedef struct {
    logic s1;
    logic s2;
    logic z;
    int   t0;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_sequencer_if bus();

  div_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  txn_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int iter_seen = 0;
  int store_seen = 0;
  int done_total = 0;
  int store_total = 0;
  int idx;
  logic [7:0] tc_pat   = 8'b0100_1101;
  logic [7:0] exp_divh = 8'b0100_1101;
  logic [7:0] exp_rnp  = 8'b1011_0010;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {bus.load_acc, bus.store_acc, bus.load_divh, bus.load_divl,
            bus.inv_op1, bus.op1_inv_cin, bus.inv_op2, bus.op2_inv_cin,
            bus.acc_inv_cin, bus.inv_result, bus.result_inv_cin, bus.inv_rem,
            bus.store_quot, bus.store_rem, bus.busy, bus.done, bus.div_zero,
            bus.result_np_0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      iter_seen = 0;
      store_seen = 0;
      bus.trial_cout = 1'b0;
    end else begin
      check_eq("one_hot", 32'($countones({bus.load_acc, bus.store_quot, bus.done}) <= 1), 1);
      if (bus.load_acc) begin
        check_eq("load_sb", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          check_eq("load_ctl", {bus.store_acc, bus.load_divh, bus.load_divl, bus.busy}, 4'hf);
          check_eq("load_inv_op1", {bus.inv_op1, bus.op1_inv_cin}, {2{sb[0].s1}});
          check_eq("load_inv_op2", {bus.inv_op2, bus.op2_inv_cin}, {2{sb[0].s2}});
        end
        iter_seen = 0;
        store_seen = 0;
      end
      if (bus.acc_inv_cin) begin
        if (iter_seen >= WIDTH) begin
          check_eq("iter_overrun", iter_seen, WIDTH - 1);
          bus.trial_cout = 1'b0;
        end else begin
          idx = iter_seen;
          bus.trial_cout = tc_pat[idx];
          #1;
          check_eq("iter_divh", bus.load_divh, exp_divh[idx]);
          check_eq("iter_rnp", bus.result_np_0, exp_rnp[idx]);
          check_eq("iter_busy_sacc", {bus.busy, bus.store_acc}, 2'b10);
        end
        iter_seen++;
      end else begin
        bus.trial_cout = 1'b0;
      end
      if (bus.store_quot || bus.store_rem) begin
        store_seen++;
        store_total++;
        check_eq("store_sb", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          check_eq("store_pair", {bus.store_quot, bus.store_rem, bus.busy}, 3'b111);
          check_eq("store_inv_res", {bus.inv_result, bus.result_inv_cin}, {2{sb[0].s1 ^ sb[0].s2}});
          check_eq("store_inv_rem", bus.inv_rem, sb[0].s2);
          check_eq("store_iters", iter_seen, WIDTH);
        end
      end
      if (bus.done) begin
        txn_t t;
        done_total++;
        check_eq("done_sb", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          t = sb.pop_front();
          check_eq("done_latency", cyc - t.t0, t.z ? 2 : WIDTH + 2);
          check_eq("done_divzero", bus.div_zero, t.z);
          check_eq("done_busy", bus.busy, 0);
          check_eq("done_stores", store_seen, t.z ? 0 : 1);
          check_eq("done_iters", iter_seen, t.z ? 0 : WIDTH);
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(n < budget), 1);
  endtask

  task automatic do_div(input logic a, input logic b, input logic zz);
    @(negedge clk);
    bus.op1_sign = a;
    bus.op2_sign = b;
    bus.op1_zero = zz;
    bus.start = 1'b1;
    sb.push_back('{a, b, zz, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
    bus.op1_sign = ~a;
    bus.op2_sign = ~b;
    bus.op1_zero = ~zz;
    wait_drain(40);
  endtask

  initial begin
    int n;
    int t_first;
    int dt;
    int st;
    bus.start = 1'b0;
    bus.op1_sign = 1'b0;
    bus.op2_sign = 1'b0;
    bus.op1_zero = 1'b0;
    bus.trial_cout = 1'b0;
    #1 rst = 1'b1;
    #1 check_eq("reset_outs", outs(), 18'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-cycle while in LOAD
    @(negedge clk);
    bus.start = 1'b1;
    sb.push_back('{1'b0, 1'b0, 1'b0, cyc + 1});
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    rst = 1'b1;
    sb.delete();
    #1 check_eq("async_reset_outs", outs(), 18'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("idle_busy", bus.busy, 0);
    end

    do_div(1'b0, 1'b0, 1'b0);
    do_div(1'b1, 1'b0, 1'b0);
    do_div(1'b0, 1'b1, 1'b0);
    do_div(1'b1, 1'b1, 1'b0);
    do_div(1'b0, 1'b0, 1'b1);
    do_div(1'b1, 1'b1, 1'b1);

    // Start held high: accepted only on IDLE edges
    @(negedge clk);
    bus.op1_sign = 1'b1;
    bus.op2_sign = 1'b0;
    bus.op1_zero = 1'b0;
    bus.start = 1'b1;
    t_first = cyc + 1;
    for (int k = 0; k < 3; k++) sb.push_back('{1'b1, 1'b0, 1'b0, t_first + k * PERIOD_DIV});
    n = 0;
    while (sb.size() > 1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("held_timeout", 32'(n < 60), 1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      #2;
      if (bus.acc_inv_cin && iter_seen == 4) break;
      n++;
    end
    check_eq("iter4_reached", 32'(n < 40), 1);
    bus.start = 1'b0;
    rst = 1'b1;
    sb.delete();
    #1 check_eq("abort_outs", outs(), 18'h1);
    dt = done_total;
    st = store_total;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("abort_no_done", done_total, dt);
    check_eq("abort_no_store", store_total, st);
    check_eq("abort_idle_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
